lc3_execute_ex: RTL and testbench
=================================

# lc3_execute_ex

Parametrised LC-3 execute stage with a valid/ready handshake, stall holding, flush, and a multi-cycle multiply unit. It sits between decode/register-read and memory-access. It computes the ALU result, the effective address (pcout), branch NZP mask, destination/source register indices and store data, all widened to WIDTH bits.

## Interface
- WIDTH, 16: datapath width in bits, 16..32; IR stays 16 bits.
- MUL_LAT, 4: multiply latency in cycles, 2..16.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- E_Control  in  7  {alu_op[2:0], pcselect1[1:0], pcselect2, op2select}.
- IR  in  16  instruction.
- npc  in  WIDTH  next PC.
- VSR1, VSR2  in  WIDTH  register operands.
- W_Control_in  in  2;  Mem_Control_in  in  1.
- flush  in  1  synchronous kill of stage contents.
- out_valid  out  1;  out_ready  in  1.
- aluout, pcout, M_Data  out  WIDTH.
- NZP  out  3;  dr  out  3;  IR_Exec  out  16.
- W_Control_out  out  2;  Mem_Control_out  out  1.
- sr1, sr2  out  3  combinational from IR.

## Operation
- imm5/offset6/offset9/offset11 sign-extended from IR to WIDTH.
- aluin1 = VSR1; aluin2 = op2select ? VSR2 : imm5.
- alu_op: 000 ADD, 001 AND, 010 NOT(aluin1), 011 PASS aluin1, 100 MUL (low WIDTH bits of product), 101 SUB (aluin1−aluin2), 110 XOR, 111 result 0. Arithmetic is modulo 2^WIDTH.
- addrin1 by pcselect1: 0 offset11, 1 offset9, 2 offset6, 3 zero. addrin2 = pcselect2 ? npc : VSR1. pcout = addrin1+addrin2 mod 2^WIDTH.
- NZP: IR[15:12]=0000 → IR[11:9]; 1100 → 111; otherwise 000.
- dr = IR[11:9] for opcodes 0001, 0101, 1001, 0010, 0110, 1010, 1110; otherwise 0.
- sr1 = IR[8:6]. sr2 is IR[2:0] when IR[13:12]=01, IR[11:9] when IR[13:12]=11, and 0 otherwise.
- M_Data = VSR2; IR_Exec = IR; control fields pass through.
- FSM:
  - IDLE: accepts when in_valid && in_ready. A non-MUL op loads the output registers at the acceptance edge and sets out_valid. A MUL op captures operands, sets cnt=MUL_LAT−1 and goes to BUSY.
  - BUSY: cnt decrements each edge. At cnt=1 the next edge loads outputs, sets out_valid and returns to IDLE.
- in_ready = reset deasserted && state==IDLE && (!out_valid || out_ready).
- Back-to-back: with out_ready=1, single-cycle ops accept every cycle.
- Output registers hold while out_valid && !out_ready. out_valid clears on an out_ready edge with no new result.
- flush: at the next edge, out_valid is cleared and BUSY aborts to IDLE. No acceptance occurs that cycle; flush wins over in_valid.

## Timing
- Reset: all registered outputs are 0, NZP=000, out_valid=0, state=IDLE, cnt=0. in_ready=0 while reset is low.
- Reset mid-BUSY returns to IDLE immediately; the partial product is discarded.
- Non-MUL latency: 1 edge. MUL latency: MUL_LAT edges from acceptance. in_ready stays low throughout BUSY.
- sr1/sr2 are combinational, with zero latency from IR.

## Configuration
- EXEC_FWD_EN defined: adds ports fwd_valid (in, 1), fwd_dr (in, 3) and fwd_data (in, WIDTH).
  - At acceptance, when fwd_valid && fwd_dr==sr1, fwd_data replaces VSR1.
  - Likewise, when fwd_valid && fwd_dr==sr2, fwd_data replaces VSR2, for both aluin2 and M_Data.
- EXEC_FWD_EN undefined: the forwarding ports are absent, and VSR1/VSR2 are used unmodified.

## Test plan
- ADD with register operand, WIDTH=16: IR=0x1042 (ADD R0,R1,R2), E_Control=7'b000_11_0_1, VSR1=0x7FFF, VSR2=0x0001.
  - Required one edge later: aluout=0x8000, dr=0, sr1=1, sr2=2, out_valid=1.
- BR with offset9: IR=0x0A05, pcselect1=1, pcselect2=1, npc=0x3001 → pcout=0x3006, NZP=101.
- MUL with MUL_LAT=4: VSR1=0x0100, VSR2=0x0101.
  - Required: aluout=0x0100, out_valid rising exactly 4 edges after acceptance, in_ready=0 for the intervening cycles.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0, no acceptance; release → next instruction accepted on that edge.
- Flush and reset during BUSY:
  - flush during BUSY → out_valid stays 0 and IDLE is reached next edge.
  - reset pulse during BUSY → all outputs 0 asynchronously.
- EXEC_FWD_EN build: fwd_valid=1, fwd_dr=1, fwd_data=0x0005, VSR1=0xFFFF, ADD imm5=3 → aluout=0x0008.

Source files
------------

// File: rtl/lc3_execute_ex_if.sv
// Bus bundle for the LC-3 execute stage: upstream handshake/operands and downstream results.
// Forwarding signals exist only when EXEC_FWD_EN is defined.
interface lc3_execute_ex_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       E_Control;
  logic [15:0]      IR;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] VSR1;
  logic [WIDTH-1:0] VSR2;
  logic [1:0]       W_Control_in;
  logic             Mem_Control_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluout;
  logic [WIDTH-1:0] pcout;
  logic [WIDTH-1:0] M_Data;
  logic [2:0]       NZP;
  logic [2:0]       dr;
  logic [15:0]      IR_Exec;
  logic [1:0]       W_Control_out;
  logic             Mem_Control_out;
  logic [2:0]       sr1;
  logic [2:0]       sr2;
`ifdef EXEC_FWD_EN
  logic             fwd_valid;
  logic [2:0]       fwd_dr;
  logic [WIDTH-1:0] fwd_data;
`endif

  modport slave (
`ifdef EXEC_FWD_EN
    input  fwd_valid, fwd_dr, fwd_data,
`endif
    input  in_valid, E_Control, IR, npc, VSR1, VSR2, W_Control_in, Mem_Control_in,
    input  flush, out_ready,
    output in_ready, out_valid, aluout, pcout, M_Data, NZP, dr, IR_Exec,
    output W_Control_out, Mem_Control_out, sr1, sr2
  );

  modport master (
`ifdef EXEC_FWD_EN
    output fwd_valid, fwd_dr, fwd_data,
`endif
    output in_valid, E_Control, IR, npc, VSR1, VSR2, W_Control_in, Mem_Control_in,
    output flush, out_ready,
    input  in_ready, out_valid, aluout, pcout, M_Data, NZP, dr, IR_Exec,
    input  W_Control_out, Mem_Control_out, sr1, sr2
  );
endinterface

// File: rtl/lc3_execute_ex.sv
// LC-3 execute stage: ALU, effective address, NZP/dr decode, valid/ready pipeline register and
// a multi-cycle multiplier. Define EXEC_FWD_EN to add operand forwarding at acceptance.
module lc3_execute_ex #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 4
) (
  input logic             clock,
  input logic             reset,
  lc3_execute_ex_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a & b;
      3'b010:  r = ~a;
      3'b011:  r = a;
      3'b101:  r = a - b;
      3'b110:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] pcout_q, pcout_d;
  logic [WIDTH-1:0] mdata_q, mdata_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [2:0]       dr_q, dr_d;
  logic [15:0]      ir_q, ir_d;
  logic [1:0]       wctl_q, wctl_d;
  logic             mctl_q, mctl_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;

  logic [2:0]              alu_op;
  logic [1:0]              pcsel1;
  logic                    pcsel2;
  logic                    op2sel;
  logic [3:0]              opcode;
  logic [2:0]              sr1_c, sr2_c;
  logic signed [WIDTH-1:0] imm5, off6, off9, off11;
  logic [WIDTH-1:0]        op1, op2;
  logic [WIDTH-1:0]        aluin1, aluin2;
  logic [WIDTH-1:0]        addrin1, addrin2, pcout_c;
  logic [2:0]              nzp_c, dr_c;
  logic [WIDTH-1:0]        mul_prod;
  logic                    in_ready;
  logic                    accept;

  assign alu_op = bus.E_Control[6:4];
  assign pcsel1 = bus.E_Control[3:2];
  assign pcsel2 = bus.E_Control[1];
  assign op2sel = bus.E_Control[0];
  assign opcode = bus.IR[15:12];

  assign sr1_c = bus.IR[8:6];
  assign sr2_c = (bus.IR[13:12] == 2'b01) ? bus.IR[2:0]  :
                 (bus.IR[13:12] == 2'b11) ? bus.IR[11:9] : 3'b000;

  assign imm5  = {{(WIDTH-5){bus.IR[4]}},   bus.IR[4:0]};
  assign off6  = {{(WIDTH-6){bus.IR[5]}},   bus.IR[5:0]};
  assign off9  = {{(WIDTH-9){bus.IR[8]}},   bus.IR[8:0]};
  assign off11 = {{(WIDTH-11){bus.IR[10]}}, bus.IR[10:0]};

`ifdef EXEC_FWD_EN
  // A result still in flight for the register being read overrides the stale register file value.
  assign op1 = (bus.fwd_valid && (bus.fwd_dr == sr1_c)) ? bus.fwd_data : bus.VSR1;
  assign op2 = (bus.fwd_valid && (bus.fwd_dr == sr2_c)) ? bus.fwd_data : bus.VSR2;
`else
  assign op1 = bus.VSR1;
  assign op2 = bus.VSR2;
`endif

  assign aluin1 = op1;
  assign aluin2 = op2sel ? op2 : imm5;

  always_comb begin
    addrin1 = '0;
    case (pcsel1)
      2'd0:    addrin1 = off11;
      2'd1:    addrin1 = off9;
      2'd2:    addrin1 = off6;
      default: addrin1 = '0;
    endcase
  end

  assign addrin2 = pcsel2 ? bus.npc : op1;
  assign pcout_c = addrin1 + addrin2;

  always_comb begin
    nzp_c = 3'b000;
    if (opcode == 4'b0000)      nzp_c = bus.IR[11:9];
    else if (opcode == 4'b1100) nzp_c = 3'b111;
    case (opcode)
      4'b0001, 4'b0101, 4'b1001, 4'b0010,
      4'b0110, 4'b1010, 4'b1110: dr_c = bus.IR[11:9];
      default:                   dr_c = 3'b000;
    endcase
  end

  // Operands are frozen for the whole BUSY window, so the product settles over MUL_LAT cycles.
  assign mul_prod = mul_a_q * mul_b_q;

  assign in_ready = reset && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    aluout_d    = aluout_q;
    pcout_d     = pcout_q;
    mdata_d     = mdata_q;
    nzp_d       = nzp_q;
    dr_d        = dr_q;
    ir_d        = ir_q;
    wctl_d      = wctl_q;
    mctl_d      = mctl_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          out_valid_d = 1'b0;
        end else if (accept) begin
          pcout_d = pcout_c;
          mdata_d = op2;
          nzp_d   = nzp_c;
          dr_d    = dr_c;
          ir_d    = bus.IR;
          wctl_d  = bus.W_Control_in;
          mctl_d  = bus.Mem_Control_in;
          if (alu_op == 3'b100) begin
            mul_a_d     = aluin1;
            mul_b_d     = aluin2;
            cnt_d       = CNT_W'(MUL_LAT - 1);
            out_valid_d = 1'b0;
            state_d     = BUSY;
          end else begin
            aluout_d    = alu_fn(alu_op, aluin1, aluin2);
            out_valid_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          aluout_d    = mul_prod;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      aluout_q    <= '0;
      pcout_q     <= '0;
      mdata_q     <= '0;
      nzp_q       <= 3'b000;
      dr_q        <= 3'b000;
      ir_q        <= '0;
      wctl_q      <= '0;
      mctl_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      aluout_q    <= aluout_d;
      pcout_q     <= pcout_d;
      mdata_q     <= mdata_d;
      nzp_q       <= nzp_d;
      dr_q        <= dr_d;
      ir_q        <= ir_d;
      wctl_q      <= wctl_d;
      mctl_q      <= mctl_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.aluout          = aluout_q;
  assign bus.pcout           = pcout_q;
  assign bus.M_Data          = mdata_q;
  assign bus.NZP             = nzp_q;
  assign bus.dr              = dr_q;
  assign bus.IR_Exec         = ir_q;
  assign bus.W_Control_out   = wctl_q;
  assign bus.Mem_Control_out = mctl_q;
  assign bus.sr1             = sr1_c;
  assign bus.sr2             = sr2_c;

endmodule

// File: tb/tb_lc3_execute_ex.sv
// Bench for lc3_execute_ex: directed vector table, handshake/flush/reset sequences and
// randomized instructions checked against a behavioural model of the LC-3 execute rules.
module tb_lc3_execute_ex;
  localparam int WIDTH   = 16;
  localparam int MUL_LAT = 4;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] md;
    logic [2:0]  nzp;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
  } exp_t;

  typedef struct {
    logic [6:0]  e;
    logic [15:0] ir;
    logic [15:0] npc;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [1:0]  wc;
    logic        mc;
    exp_t        x;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  lc3_execute_ex_if #(.WIDTH(WIDTH)) bus ();

  lc3_execute_ex #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic exp_t model(input logic [6:0] e, input logic [15:0] ir,
                                 input logic [15:0] npc, input logic [15:0] v1,
                                 input logic [15:0] v2);
    exp_t   x;
    longint a, b, r, ad1, ad2;
    int     opc;
    a = longint'(v1);
    b = e[0] ? longint'(v2) : longint'(sx(int'(ir[4:0]), 5));
    case (e[6:4])
      3'd0:    r = a + b;
      3'd1:    r = a & b;
      3'd2:    r = ~a;
      3'd3:    r = a;
      3'd4:    r = a * b;
      3'd5:    r = a - b;
      3'd6:    r = a ^ b;
      default: r = 0;
    endcase
    x.alu = r[15:0];
    case (e[3:2])
      2'd0:    ad1 = longint'(sx(int'(ir[10:0]), 11));
      2'd1:    ad1 = longint'(sx(int'(ir[8:0]), 9));
      2'd2:    ad1 = longint'(sx(int'(ir[5:0]), 6));
      default: ad1 = 0;
    endcase
    ad2 = e[1] ? longint'(npc) : longint'(v1);
    r = ad1 + ad2;
    x.pc  = r[15:0];
    x.md  = v2;
    opc   = int'(ir[15:12]);
    x.nzp = (opc == 0) ? ir[11:9] : (opc == 12) ? 3'b111 : 3'b000;
    x.dr  = (opc inside {1, 2, 5, 6, 9, 10, 14}) ? ir[11:9] : 3'b000;
    x.sr1 = ir[8:6];
    x.sr2 = (ir[13:12] == 2'b01) ? ir[2:0] : (ir[13:12] == 2'b11) ? ir[11:9] : 3'b000;
    return x;
  endfunction

  task automatic drive(input logic [6:0] e, input logic [15:0] ir, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [1:0] wc, input logic mc);
    bus.E_Control      = e;
    bus.IR             = ir;
    bus.npc            = npc;
    bus.VSR1           = v1;
    bus.VSR2           = v2;
    bus.W_Control_in   = wc;
    bus.Mem_Control_in = mc;
  endtask

  // Presents one instruction with out_ready high and waits until its result is valid.
  task automatic issue(input logic [6:0] e, input logic [15:0] ir, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [1:0] wc, input logic mc, output int lat);
    int k;
    bit rdy_busy;
    @(negedge clock);
    drive(e, ir, npc, v1, v2, wc, mc);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (k == 20) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    lat      = 1;
    rdy_busy = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_busy = 1'b1;
      @(posedge clock);
      #1;
      lat++;
    end
    if (e[6:4] == 3'b100) chk("busy_in_ready", {31'b0, rdy_busy}, 32'd0);
  endtask

  task automatic check_out(input string tag, input exp_t x, input logic [15:0] ir,
                           input logic [1:0] wc, input logic mc);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".aluout"}, 32'(bus.aluout), 32'(x.alu));
    chk({tag, ".pcout"}, 32'(bus.pcout), 32'(x.pc));
    chk({tag, ".mdata"}, 32'(bus.M_Data), 32'(x.md));
    chk({tag, ".nzp"}, 32'(bus.NZP), 32'(x.nzp));
    chk({tag, ".dr"}, 32'(bus.dr), 32'(x.dr));
    chk({tag, ".sr1"}, 32'(bus.sr1), 32'(x.sr1));
    chk({tag, ".sr2"}, 32'(bus.sr2), 32'(x.sr2));
    chk({tag, ".ir_exec"}, 32'(bus.IR_Exec), 32'(ir));
    chk({tag, ".wctl"}, 32'(bus.W_Control_out), 32'(wc));
    chk({tag, ".mctl"}, 32'(bus.Mem_Control_out), 32'(mc));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    int          lat;
    exp_t        x;
    logic [15:0] held;
    logic [6:0]  e;
    logic [15:0] ir, npc, v1, v2;
    logic [1:0]  wc;
    logic        mc;

    tbl[0] = '{7'b000_11_0_1, 16'h1042, 16'h0000, 16'h7FFF, 16'h0001, 2'b01, 1'b0,
               '{16'h8000, 16'h7FFF, 16'h0001, 3'd0, 3'd0, 3'd1, 3'd2}};
    tbl[1] = '{7'b011_01_1_0, 16'h0A05, 16'h3001, 16'h1234, 16'h0000, 2'b00, 1'b0,
               '{16'h1234, 16'h3006, 16'h0000, 3'd5, 3'd0, 3'd0, 3'd0}};
    tbl[2] = '{7'b001_11_0_0, 16'h5A7F, 16'h0000, 16'hA5C3, 16'h0F0F, 2'b01, 1'b0,
               '{16'hA5C3, 16'hA5C3, 16'h0F0F, 3'd0, 3'd5, 3'd1, 3'd7}};
    tbl[3] = '{7'b010_11_0_0, 16'h973F, 16'h0000, 16'h00FF, 16'h0000, 2'b10, 1'b0,
               '{16'hFF00, 16'h00FF, 16'h0000, 3'd0, 3'd3, 3'd4, 3'd7}};
    tbl[4] = '{7'b101_10_0_1, 16'h64FE, 16'h0000, 16'h0003, 16'h0005, 2'b11, 1'b1,
               '{16'hFFFE, 16'h0001, 16'h0005, 3'd0, 3'd2, 3'd3, 3'd0}};
    tbl[5] = '{7'b110_00_1_1, 16'h4FFF, 16'h0000, 16'hF0F0, 16'hFF00, 2'b00, 1'b1,
               '{16'h0FF0, 16'hFFFF, 16'hFF00, 3'd0, 3'd0, 3'd7, 3'd0}};
    tbl[6] = '{7'b111_11_0_1, 16'hC1C0, 16'h0000, 16'h4321, 16'h1357, 2'b10, 1'b0,
               '{16'h0000, 16'h4321, 16'h1357, 3'd7, 3'd0, 3'd7, 3'd0}};
    tbl[7] = '{7'b011_01_1_0, 16'h3E03, 16'h2FFE, 16'h1111, 16'hBEEF, 2'b00, 1'b1,
               '{16'h1111, 16'h3001, 16'hBEEF, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[8] = '{7'b000_01_1_0, 16'hE5FF, 16'h8000, 16'h0000, 16'h0000, 2'b01, 1'b0,
               '{16'hFFFF, 16'h7FFF, 16'h0000, 3'd0, 3'd2, 3'd7, 3'd0}};
    tbl[9] = '{7'b100_11_0_1, 16'h1042, 16'h0000, 16'h0100, 16'h0101, 2'b00, 1'b0,
               '{16'h0100, 16'h0100, 16'h0101, 3'd0, 3'd0, 3'd1, 3'd2}};

    drive(7'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
`ifdef EXEC_FWD_EN
    bus.fwd_valid = 1'b0;
    bus.fwd_dr    = 3'd0;
    bus.fwd_data  = '0;
`endif

    // Reset state
    #3 reset = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.aluout", 32'(bus.aluout), 32'd0);
    chk("rst.pcout", 32'(bus.pcout), 32'd0);
    chk("rst.nzp", 32'(bus.NZP), 32'd0);
    chk("rst.ir_exec", 32'(bus.IR_Exec), 32'd0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst.release_ready", 32'(bus.in_ready), 32'd1);

    // Combinational source register decode
    bus.IR = 16'h3E03;
    #1;
    chk("comb.sr1_a", 32'(bus.sr1), 32'd0);
    chk("comb.sr2_a", 32'(bus.sr2), 32'd7);
    bus.IR = 16'h5A7F;
    #1;
    chk("comb.sr1_b", 32'(bus.sr1), 32'd1);
    chk("comb.sr2_b", 32'(bus.sr2), 32'd7);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].e, tbl[i].ir, tbl[i].npc, tbl[i].v1, tbl[i].v2, tbl[i].wc, tbl[i].mc, lat);
      chk($sformatf("tbl%0d.latency", i), 32'(lat),
          (tbl[i].e[6:4] == 3'b100) ? 32'(MUL_LAT) : 32'd1);
      check_out($sformatf("tbl%0d", i), tbl[i].x, tbl[i].ir, tbl[i].wc, tbl[i].mc);
    end

    // Back-to-back single-cycle ops, then out_valid drops with no new input
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(7'b000_11_0_1, 16'h1042, 16'h0000, 16'(i * 16'h0111), 16'(16'h1000 + i), 2'b00, 1'b0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("b2b%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clock);
      #1;
      chk($sformatf("b2b%0d.valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("b2b%0d.aluout", i), 32'(bus.aluout), 32'(16'(i * 16'h0111 + 16'h1000 + i)));
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Stall: result A held while out_ready is low, B accepted on release
    @(negedge clock);
    drive(7'b000_11_0_1, 16'h1042, 16'h0000, 16'h0001, 16'h0002, 2'b00, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("stall.a_valid", 32'(bus.out_valid), 32'd1);
    chk("stall.a_alu", 32'(bus.aluout), 32'h0003);
    @(negedge clock);
    bus.VSR1 = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      @(posedge clock);
      #1;
      chk($sformatf("stall%0d.valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d.alu", i), 32'(bus.aluout), 32'h0003);
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall.release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("stall.b_valid", 32'(bus.out_valid), 32'd1);
    chk("stall.b_alu", 32'(bus.aluout), 32'h0012);

    // Flush beats in_valid while idle
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.VSR1      = 16'h0001;
    @(posedge clock);
    #1;
    held = bus.aluout;
    chk("flush_idle.pre_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clock);
    bus.VSR1  = 16'h0777;
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    chk("flush_idle.valid", 32'(bus.out_valid), 32'd0);
    chk("flush_idle.no_accept", 32'(bus.aluout), 32'(held));
    @(negedge clock);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Flush during BUSY aborts the multiply
    @(negedge clock);
    drive(7'b100_11_0_1, 16'h1042, 16'h0000, 16'h0003, 16'h0005, 2'b00, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("flush_busy.in_ready_busy", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    chk("flush_busy.valid", 32'(bus.out_valid), 32'd0);
    chk("flush_busy.idle", 32'(bus.in_ready), 32'd1);
    @(negedge clock);
    bus.flush = 1'b0;
    repeat (MUL_LAT + 1) @(posedge clock);
    #1;
    chk("flush_busy.no_late_result", 32'(bus.out_valid), 32'd0);

    // Reset pulse during BUSY clears outputs at once
    @(negedge clock);
    drive(7'b100_10_0_1, 16'h1042, 16'h0000, 16'h0100, 16'h0101, 2'b11, 1'b1);
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy.valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy.pcout", 32'(bus.pcout), 32'd0);
    chk("rst_busy.wctl", 32'(bus.W_Control_out), 32'd0);
    chk("rst_busy.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_busy.idle", 32'(bus.in_ready), 32'd1);
    repeat (MUL_LAT + 1) @(posedge clock);
    #1;
    chk("rst_busy.no_late_result", 32'(bus.out_valid), 32'd0);

`ifdef EXEC_FWD_EN
    bus.fwd_valid = 1'b1;
    bus.fwd_dr    = 3'd1;
    bus.fwd_data  = 16'h0005;
    issue(7'b000_11_0_0, 16'h1063, 16'h0000, 16'hFFFF, 16'h0000, 2'b00, 1'b0, lat);
    chk("fwd.aluout", 32'(bus.aluout), 32'h0008);
    bus.fwd_valid = 1'b0;
`endif

    // Randomized instructions against the model
    for (int i = 0; i < 150; i++) begin
      e   = 7'($urandom);
      ir  = 16'($urandom);
      npc = 16'($urandom);
      v1  = 16'($urandom);
      v2  = 16'($urandom);
      wc  = 2'($urandom);
      mc  = 1'($urandom);
      issue(e, ir, npc, v1, v2, wc, mc, lat);
      x = model(e, ir, npc, v1, v2);
      chk($sformatf("rnd%0d.latency", i), 32'(lat), (e[6:4] == 3'b100) ? 32'(MUL_LAT) : 32'd1);
      check_out($sformatf("rnd%0d", i), x, ir, wc, mc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
